// File: rtl/nn_mac_avs.sv
// nn_mac_avs: Avalon-MM slave wrapping a pipelined signed 16x16 MAC with an 8-word register map.
// Latency: an INPUT write reaches ACC/COUNT MUL_STAGES cycles after it is accepted; read data arrives 1 cycle after acceptance.
// Backpressure: waitrequest stalls ACC/COUNT reads, CLEAR writes and WEIGHT writes while products are in flight.
// Optional build macro NN_MAC_PERF_EN: address 7 returns a saturating stall-cycle counter instead of the ID word.
module nn_mac_avs #(
   parameter int MUL_STAGES = 2,
   parameter int TARGET_W   = 16
) (
   input  logic          clk_clk,
   input  logic          reset_reset_n,
   input  logic [2:0]    avs_address,
   input  logic          avs_read,
   input  logic          avs_write,
   input  logic [31:0]   avs_writedata,
   input  logic [3:0]    avs_byteenable,
   output logic [31:0]   avs_readdata,
   output logic          avs_readdatavalid,
   output logic          avs_waitrequest,
   output logic          irq
);

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_STATUS = 3'd1;
   localparam logic [2:0] A_WEIGHT = 3'd2;
   localparam logic [2:0] A_INPUT  = 3'd3;
   localparam logic [2:0] A_ACC    = 3'd4;
   localparam logic [2:0] A_COUNT  = 3'd5;
   localparam logic [2:0] A_TARGET = 3'd6;
   localparam logic [2:0] A_ID     = 3'd7;
   localparam logic [31:0] ID_WORD = 32'h4E4E_0001;

   logic                irq_en;
   logic                relu;
   logic                done;
   logic                ovf;
   logic [15:0]         weight;
   logic [15:0]         inp;
   logic [31:0]         acc;
   logic [TARGET_W-1:0] count;
   logic [TARGET_W-1:0] target;

   // product pipeline: vld[i]/prod[i] hold the product launched i+1 edges ago
   logic [MUL_STAGES-1:0] vld;
   logic [31:0]           prod [MUL_STAGES];

   logic                busy;
   logic                stall_req;
   logic                wr_acc;
   logic                rd_acc;
   logic                launch;
   logic                clear_acc;
   logic                w1c;
   logic                complete;
   logic [31:0]         tail;
   logic signed [31:0]  mul;
   logic [32:0]         sum;
   logic [31:0]         acc_nxt;
   logic                sat;
   logic [TARGET_W-1:0] count_inc;
   logic                hit;
   logic [31:0]         rd_mux;
   logic                unused_ok;

`ifdef NN_MAC_PERF_EN
   logic [31:0]         stall_cnt;
`endif

   assign busy = |vld;

   // classify the pending request: only accesses that touch in-flight state are stalled
   always_comb begin
      stall_req = 1'b0;
      if (avs_write) begin
         stall_req = (avs_address == A_CTRL && avs_byteenable[0] && avs_writedata[0]) ||
                     (avs_address == A_WEIGHT);
      end else if (avs_read) begin
         stall_req = (avs_address == A_ACC) || (avs_address == A_COUNT);
      end
   end

   assign avs_waitrequest = reset_reset_n & busy & stall_req;
   assign wr_acc    = avs_write & ~avs_waitrequest;
   assign rd_acc    = avs_read & ~avs_write & ~avs_waitrequest;
   assign launch    = wr_acc && avs_address == A_INPUT && avs_byteenable[1:0] == 2'b11;
   assign clear_acc = wr_acc && avs_address == A_CTRL && avs_byteenable[0] && avs_writedata[0];
   assign w1c       = wr_acc && avs_address == A_STATUS && avs_byteenable[0];

   // WEIGHT is used as stored before this edge, so a product always sees the weight of its launch cycle
   assign mul = 32'($signed(weight)) * 32'($signed(avs_writedata[15:0]));

   assign complete  = vld[MUL_STAGES-1];
   assign tail      = prod[MUL_STAGES-1];
   assign count_inc = count + TARGET_W'(1);
   assign hit       = complete && (target != '0) && (count_inc == target);

   // saturating 32-bit accumulate of the product leaving the pipeline
   always_comb begin
      sum     = {acc[31], acc} + {tail[31], tail};
      acc_nxt = sum[31:0];
      sat     = 1'b0;
      if (sum[32] != sum[31]) begin
         sat     = 1'b1;
         acc_nxt = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end

   // register read multiplexer; RELU only masks the value returned, never the stored sum
   always_comb begin
      rd_mux = '0;
      case (avs_address)
         A_CTRL:   rd_mux[2:1] = {relu, irq_en};
         A_STATUS: rd_mux[2:0] = {ovf, done, busy};
         A_WEIGHT: rd_mux[15:0] = weight;
         A_INPUT:  rd_mux[15:0] = inp;
         A_ACC:    rd_mux = (relu && acc[31]) ? 32'h0 : acc;
         A_COUNT:  rd_mux[TARGET_W-1:0] = count;
         A_TARGET: rd_mux[TARGET_W-1:0] = target;
         A_ID: begin
`ifdef NN_MAC_PERF_EN
            rd_mux = stall_cnt;
`else
            rd_mux = ID_WORD;
`endif
         end
         default:  rd_mux = '0;
      endcase
   end

   assign unused_ok = &{1'b0, avs_writedata[31:16], avs_byteenable[3:2]};

   // read response strobe and registered interrupt
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         avs_readdatavalid <= 1'b0;
         avs_readdata      <= '0;
         irq               <= 1'b0;
      end else begin
         avs_readdatavalid <= rd_acc;
         avs_readdata      <= rd_acc ? rd_mux : 32'h0;
         irq               <= done & irq_en;
      end
   end

   // multiplier pipeline shift
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         vld <= '0;
         for (int i = 0; i < MUL_STAGES; i++) prod[i] <= '0;
      end else begin
         vld[0]  <= launch;
         prod[0] <= mul;
         for (int i = MUL_STAGES - 1; i > 0; i--) begin
            vld[i]  <= vld[i-1];
            prod[i] <= prod[i-1];
         end
      end
   end

   // byte-lane writes to the programmable registers
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         irq_en <= 1'b0;
         relu   <= 1'b0;
         weight <= '0;
         inp    <= '0;
         target <= '0;
      end else if (wr_acc) begin
         case (avs_address)
            A_CTRL: if (avs_byteenable[0]) {relu, irq_en} <= avs_writedata[2:1];
            A_WEIGHT: begin
               if (avs_byteenable[0]) weight[7:0]  <= avs_writedata[7:0];
               if (avs_byteenable[1]) weight[15:8] <= avs_writedata[15:8];
            end
            A_INPUT: begin
               if (avs_byteenable[0]) inp[7:0]  <= avs_writedata[7:0];
               if (avs_byteenable[1]) inp[15:8] <= avs_writedata[15:8];
            end
            A_TARGET: begin
               for (int i = 0; i < TARGET_W; i++)
                  if (avs_byteenable[i/8]) target[i] <= avs_writedata[i];
            end
            default: ;
         endcase
      end
   end

   // accumulator, completion counter and sticky status; a set beats a coincident W1C
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         acc   <= '0;
         count <= '0;
         done  <= 1'b0;
         ovf   <= 1'b0;
      end else if (clear_acc) begin
         acc   <= '0;
         count <= '0;
         done  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         if (complete) begin
            acc   <= acc_nxt;
            count <= count_inc;
         end
         if (hit)                           done <= 1'b1;
         else if (w1c && avs_writedata[1])  done <= 1'b0;
         if (complete && sat)               ovf <= 1'b1;
         else if (w1c && avs_writedata[2])  ovf <= 1'b0;
      end
   end

`ifdef NN_MAC_PERF_EN
   // count cycles a request is held off, sticking at all-ones
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n || clear_acc) begin
         stall_cnt <= '0;
      end else if ((avs_read | avs_write) && avs_waitrequest && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_nn_mac_avs.sv
// tb_nn_mac_avs: directed bench for nn_mac_avs with a transaction-level reference model.
// Model applies products from a timestamped queue; a negedge process compares every output every cycle.
// Literal expectations in the main sequence pin the model to hand-computed values.
module tb_nn_mac_avs;
   localparam int MS = 2;
   localparam int TW = 16;
`ifdef NN_MAC_PERF_EN
   localparam logic [31:0] ID_EXP = 32'h0;
`else
   localparam logic [31:0] ID_EXP = 32'h4E4E_0001;
`endif
   localparam logic [31:0] CMASK = 32'((64'd1 << TW) - 64'd1);

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid, avs_waitrequest, irq;

   always #5 clk = ~clk;

   nn_mac_avs #(.MUL_STAGES(MS), .TARGET_W(TW)) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address),
      .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
      .avs_byteenable(avs_byteenable), .avs_readdata(avs_readdata),
      .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest), .irq(irq));

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int          m_acc;
   int unsigned m_count, m_target, m_stall;
   bit          m_done, m_ovf, m_irq_en, m_relu, m_rdv, m_irq;
   logic [15:0] m_weight, m_inp;
   logic [31:0] m_rdata;
   int          due_q[$];
   int          prd_q[$];
   int          edge_n = 0;

   function automatic bit exp_wait();
      if (!rst_n || due_q.size() == 0) return 1'b0;
      if (avs_write) return (avs_address == 3'd0 && avs_byteenable[0] && avs_writedata[0]) || avs_address == 3'd2;
      if (avs_read)  return avs_address == 3'd4 || avs_address == 3'd5;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0: return {29'b0, m_relu, m_irq_en, 1'b0};
         3'd1: return {29'b0, m_ovf, m_done, due_q.size() != 0};
         3'd2: return {16'b0, m_weight};
         3'd3: return {16'b0, m_inp};
         3'd4: return (m_relu && m_acc < 0) ? 32'h0 : m_acc;
         3'd5: return m_count;
         3'd6: return m_target;
         default: begin
`ifdef NN_MAC_PERF_EN
            return m_stall;
`else
            return 32'h4E4E_0001;
`endif
         end
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   task automatic model_step();
      bit wt, aw, ar, launch, irq_n;
      int p, p0;
      longint s;
      logic [31:0] rv, t;
      edge_n++;
      if (!rst_n) begin
         m_acc = 0; m_count = 0; m_target = 0; m_stall = 0;
         m_done = 0; m_ovf = 0; m_irq_en = 0; m_relu = 0; m_rdv = 0; m_irq = 0;
         m_weight = 0; m_inp = 0; m_rdata = 0;
         due_q.delete(); prd_q.delete();
         return;
      end
      wt = exp_wait();
      if ((avs_read || avs_write) && wt && m_stall != 32'hFFFF_FFFF) m_stall++;
      aw = avs_write && !wt;
      ar = avs_read && !avs_write && !wt;
      irq_n = m_done && m_irq_en;
      rv = ar ? m_read(avs_address) : 32'h0;
      launch = aw && avs_address == 3'd3 && avs_byteenable[1:0] == 2'b11;
      p = int'($signed(m_weight)) * int'($signed(avs_writedata[15:0]));
      if (aw) begin
         case (avs_address)
            3'd0: if (avs_byteenable[0]) begin
               m_irq_en = avs_writedata[1];
               m_relu   = avs_writedata[2];
               if (avs_writedata[0]) begin
                  m_acc = 0; m_count = 0; m_done = 0; m_ovf = 0; m_stall = 0;
               end
            end
            3'd1: if (avs_byteenable[0]) begin
               if (avs_writedata[1]) m_done = 0;
               if (avs_writedata[2]) m_ovf = 0;
            end
            3'd2: begin t = merge({16'b0, m_weight}, avs_writedata, {2'b0, avs_byteenable[1:0]}); m_weight = t[15:0]; end
            3'd3: begin t = merge({16'b0, m_inp}, avs_writedata, {2'b0, avs_byteenable[1:0]}); m_inp = t[15:0]; end
            3'd6: m_target = merge(m_target, avs_writedata, avs_byteenable) & CMASK;
            default: ;
         endcase
      end
      while (due_q.size() > 0 && due_q[0] == edge_n) begin
         void'(due_q.pop_front());
         p0 = prd_q.pop_front();
         s = longint'(m_acc) + longint'(p0);
         if (s > 64'sd2147483647)       begin m_acc = 32'h7FFF_FFFF; m_ovf = 1; end
         else if (s < -64'sd2147483648) begin m_acc = 32'h8000_0000; m_ovf = 1; end
         else m_acc = int'(s);
         m_count = (m_count + 1) & CMASK;
         if (m_target != 0 && m_count == m_target) m_done = 1;
      end
      if (launch) begin
         due_q.push_back(edge_n + MS);
         prd_q.push_back(p);
      end
      m_rdv = ar; m_rdata = rv; m_irq = irq_n;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // every-cycle comparison of all outputs against the model
   initial forever begin
      @(negedge clk);
      check("readdatavalid", {31'b0, avs_readdatavalid}, {31'b0, m_rdv});
      check("readdata", avs_readdata, m_rdv ? m_rdata : 32'h0);
      check("irq", {31'b0, irq}, {31'b0, m_irq});
      check("waitrequest", {31'b0, avs_waitrequest}, {31'b0, exp_wait()});
   end

   // ---------------- bus driver ----------------
   task automatic bus(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] q, output int waits);
      avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d; avs_byteenable = be;
      waits = 0; q = 32'h0;
      @(negedge clk);
      while (avs_waitrequest && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (waits >= 200) begin
         n_total++;
         $display("FAIL accept_timeout: addr %0d still stalled after %0d cycles", a, waits);
      end
      @(posedge clk); #1;
      avs_read = 0; avs_write = 0; avs_byteenable = 4'h0;
      if (rd && !wr) begin
         @(negedge clk);
         q = avs_readdata;
         @(posedge clk); #1;
      end
   endtask

   task automatic wrb(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] q; int w;
      bus(1'b0, 1'b1, a, d, be, q, w);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      wrb(a, d, 4'hF);
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] q);
      int w;
      bus(1'b1, 1'b0, a, 32'h0, 4'h0, q, w);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] q;
      int w, n;
      rst_n = 0; avs_read = 0; avs_write = 0; avs_address = 0; avs_writedata = 0; avs_byteenable = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // ID / perf word straight out of reset
      rd(3'd7, q);  check("id_word", q, ID_EXP);
      rd(3'd4, q);  check("acc_reset", q, 32'h0);

      // 3 * (-5 + 7 + 10) = 36, read stalls MS cycles behind the last launch
      wr(3'd2, 32'd3);
      wr(3'd3, 32'hFFFF_FFFB);
      wr(3'd3, 32'd7);
      wr(3'd3, 32'd10);
      bus(1'b1, 1'b0, 3'd4, 32'h0, 4'h0, q, w);
      check("acc_stall_cycles", w, MS);
      check("acc_36", q, 32'd36);
      rd(3'd5, q);  check("count_3", q, 32'd3);
      rd(3'd1, q);  check("status_idle", q, 32'h0);

      // 3 * 0x3FFF0001 overflows positive
      wr(3'd0, 32'h1);
      wr(3'd2, 32'h7FFF);
      repeat (3) wr(3'd3, 32'h7FFF);
      rd(3'd4, q);  check("acc_sat", q, 32'h7FFF_FFFF);
      rd(3'd1, q);  check("status_ovf", q, 32'h4);
      rd(3'd5, q);  check("count_sat_3", q, 32'd3);
      wr(3'd1, 32'h4);
      rd(3'd1, q);  check("ovf_w1c", q, 32'h0);

      // DONE at the 2nd completion, irq one cycle later
      wr(3'd0, 32'h1);
      wr(3'd6, 32'd2);
      wr(3'd0, 32'h2);
      wr(3'd3, 32'h7FFF);
      wr(3'd3, 32'h7FFF);
      n = 0;
      while (!irq && n < 20) begin @(posedge clk); #1; n++; end
      check("irq_latency", n, MS + 1);
      rd(3'd1, q);  check("status_done", q, 32'h2);
      wr(3'd1, 32'h2);
      check("irq_after_w1c", {31'b0, irq}, 32'h1);
      @(posedge clk); #1;
      check("irq_dropped", {31'b0, irq}, 32'h0);
      rd(3'd1, q);  check("done_w1c", q, 32'h0);
      wr(3'd0, 32'h0);

      // RELU masks a negative sum on read only
      wr(3'd0, 32'h1);
      wr(3'd2, 32'h0000_FFFD);
      wr(3'd3, 32'd5);
      wr(3'd0, 32'h4);
      rd(3'd4, q);  check("acc_relu", q, 32'h0);
      wr(3'd0, 32'h0);
      rd(3'd4, q);  check("acc_neg15", q, 32'hFFFF_FFF1);
      wr(3'd0, 32'h1);
      rd(3'd4, q);  check("acc_clear", q, 32'h0);
      rd(3'd5, q);  check("count_clear", q, 32'h0);

      // partial byte-lane writes: INPUT lane 0 alone does not launch
      wrb(3'd3, 32'h0000_12AB, 4'b0001);
      rd(3'd3, q);  check("input_lane0", q, 32'h0000_00AB);
      rd(3'd5, q);  check("no_launch", q, 32'h0);
      wrb(3'd2, 32'h0000_1100, 4'b0010);
      rd(3'd2, q);  check("weight_lane1", q, 32'h0000_11FD);

      // reset right behind a launch discards the product
      wr(3'd2, 32'd2);
      wr(3'd3, 32'd4);
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      rd(3'd4, q);  check("acc_after_rst", q, 32'h0);
      rd(3'd5, q);  check("count_after_rst", q, 32'h0);
      rd(3'd1, q);  check("status_after_rst", q, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      rd(3'd4, q);  check("no_late_acc", q, 32'h0);
      check("irq_after_rst", {31'b0, irq}, 32'h0);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/nn_mac_avs.md
Name: nn_mac_avs

Overview:
- Avalon-MM slave, the responder end of the Nios II data master, for the neural-net accelerator datapath.
- Implements a pipelined signed 16x16 multiply-accumulate engine behind an 8-word register map.
- The Nios writes weights and inputs, then reads back the accumulated neuron sum. An interrupt can be raised after a programmed number of MAC operations.
- Instantiated inside the Qsys system on the SoC clock.

Parameters:
- MUL_STAGES, 2, multiplier pipeline depth in cycles; legal range 1..4.
- TARGET_W, 16, width of the COUNT and TARGET registers.

Ports:
- clk_clk  in  1  SoC clock.
- reset_reset_n  in  1  synchronous, active-low reset.
- avs_address  in  3  word address.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  32  write data.
- avs_byteenable  in  4  byte lanes for writes.
- avs_readdata  out  32  read data; valid when avs_readdatavalid is high.
- avs_readdatavalid  out  1  one-cycle read response strobe.
- avs_waitrequest  out  1  stall; the request is held by the master while this is high.
- irq  out  1  level interrupt.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-low. While reset_reset_n is low:
  - avs_readdata=0, avs_readdatavalid=0, irq=0, avs_waitrequest=0.
  - All registers are 0 and the pipeline valid bits are cleared.
  - Reset mid-operation discards in-flight products.
- Register map, by word address:
  - 0 CTRL (RW): bit0 CLEAR is self-clearing and reads 0. bit1 IRQ_EN. bit2 RELU.
  - 1 STATUS: bit0 BUSY (RO). bit1 DONE (sticky, write-1-to-clear). bit2 OVF (sticky, write-1-to-clear).
  - 2 WEIGHT (RW): signed value in [15:0]; bits [31:16] read 0.
  - 3 INPUT (RW): signed value in [15:0]. A write launches the product WEIGHT*INPUT into the pipeline. A read returns the last value written.
  - 4 ACC (RO): signed 32-bit accumulator. When RELU=1 and ACC<0, reads return 0; the stored value is unchanged.
  - 5 COUNT (RO): completed MACs, wraps modulo 2^TARGET_W.
  - 6 TARGET (RW): MAC count at which DONE is set; 0 disables DONE.
  - 7 ID (RO): 32'h4E4E_0001.
- Byte enables: honoured on CTRL, WEIGHT, INPUT and TARGET. A write to INPUT launches a MAC only if byteenable[1:0]==2'b11. STATUS W1C uses byte lane 0.
- Handshake:
  - A request is accepted on any edge where (read|write) and !waitrequest.
  - Reads: avs_readdatavalid pulses exactly 1 cycle after acceptance, with the data; readdata returns to 0 otherwise.
  - Writes: no response strobe.
  - avs_waitrequest is combinational. It is high when BUSY and the request is a read of ACC or COUNT, a write of CTRL with CLEAR=1, or a write of WEIGHT. It is low for all other accesses, so INPUT writes may issue back-to-back, 1 per cycle.
  - If read and write are both asserted, the write executes and the read is ignored (no readdatavalid).
- Pipeline:
  - An INPUT write accepted at edge 0 produces a 32-bit signed product, sign-extended.
  - The product is added to ACC, and COUNT is incremented, at edge MUL_STAGES.
  - BUSY = OR of the pipeline valid bits.
  - WEIGHT is sampled at INPUT acceptance.
- Arithmetic:
  - ACC addition saturates to 32'h7FFF_FFFF or 32'h8000_0000.
  - On saturation, OVF is set.
  - Product overflow is impossible except (-32768)*(-32768)=2^30, which fits.
- DONE is set on the edge where COUNT becomes equal to TARGET (TARGET!=0). If set and W1C coincide, set wins.
- irq is registered: irq <= DONE & IRQ_EN, i.e. 1 cycle after either term changes.
- CLEAR zeroes ACC, COUNT, DONE and OVF on the accept edge. It never coincides with a completion, because of the stall.

Optional Feature:
- Macro NN_MAC_PERF_EN.
- Defined:
  - A 32-bit stall counter increments every cycle that (read|write)&waitrequest.
  - The counter saturates at all-ones and is cleared by CLEAR or reset.
  - Address 7 reads the counter instead of ID.
- Undefined: no counter logic is generated, and address 7 reads 32'h4E4E_0001.

Test Plan:
- Release reset, read addr 7 -> readdatavalid exactly 1 cycle after acceptance with readdata=32'h4E4E_0001; without the macro, and with the macro the value is 0.
- WEIGHT=3, then INPUT=-5, 7, 10 on consecutive cycles, then immediately read ACC -> waitrequest high until the last completion at MUL_STAGES cycles, then ACC=36, COUNT=3, BUSY=0.
- WEIGHT=16'h7FFF, INPUT=16'h7FFF issued 3 times -> ACC=32'h7FFF_FFFF, STATUS=3'b100, COUNT=3.
- TARGET=2, CTRL=3'b010, two INPUT writes -> DONE=1 at the 2nd completion, irq high 1 cycle later. Write STATUS=2 -> DONE=0, then irq low next cycle.
- WEIGHT=-3, INPUT=5, CTRL RELU=1 -> ACC reads 0. Set RELU=0 -> reads 32'hFFFF_FFF1. CLEAR -> ACC=0, COUNT=0.
- Issue INPUT=4 with WEIGHT=2, then assert reset the next cycle for 1 cycle -> ACC=0, COUNT=0, BUSY=0, irq=0, and no late accumulation occurs.
